// File: rtl/iobuf_dir_ctrl_pkg.sv
// Shared state encoding and turnaround-counter helpers for the bidirectional pad controller.
// Declarations only: no latency, no flow control.
package iobuf_dir_ctrl_pkg;

   localparam int TURN_CW  = 4;
   localparam int TURN_MAX = (1 << TURN_CW) - 1;

   typedef enum logic [1:0] {
      RECV    = 2'd0,
      TURN_TX = 2'd1,
      DRIVE   = 2'd2,
      TURN_RX = 2'd3
   } dir_state_t;

   // Counter preload for a gap of `cycles` released cycles, kept inside 1..TURN_MAX.
   function automatic logic [TURN_CW-1:0] turn_load(input int cycles);
      int c;
      c = cycles;
      if (c < 1)        c = 1;
      if (c > TURN_MAX) c = TURN_MAX;
      return TURN_CW'(c - 1);
   endfunction

   function automatic int clamp_sync(input int stages);
      int s;
      s = stages;
      if (s < 1) s = 1;
      if (s > 4) s = 4;
      return s;
   endfunction

endpackage

// File: rtl/iobuf_dir_sync.sv
// Plain STAGES-deep shift register, cleared asynchronously; latency STAGES cycles.
// No backpressure: shifts every cycle.
module iobuf_dir_sync #(
   parameter int STAGES = 2,
   parameter int W      = 9
) (
   input  logic         C,
   input  logic         CLR,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stg [STAGES];

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         for (int k = 0; k < STAGES; k++) stg[k] <= '0;
      end else begin
         stg[0] <= d;
         for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/iobuf_dir_ctrl.sv
// Direction controller for a registered tristate pad; RX latency SYNC_STAGES, TX_READY only in DRIVE with DIR_REQ.
// Optional readback mismatch flag under IOBUF_DIR_READBACK_CHECK_EN (ERR tied low otherwise).
module iobuf_dir_ctrl
   import iobuf_dir_ctrl_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             DIR_REQ,
   input  logic [WIDTH-1:0] TX_DATA,
   input  logic             TX_VALID,
   output logic             TX_READY,
   output logic [WIDTH-1:0] RX_DATA,
   output logic             RX_VALID,
   output logic             ERR,
   output logic [WIDTH-1:0] I,
   output logic             T,
   input  logic [WIDTH-1:0] O
);

   localparam int                 SYNC_N    = clamp_sync(SYNC_STAGES);
   localparam logic [TURN_CW-1:0] TURN_LOAD = turn_load(TURN_CYCLES);

   dir_state_t         state_q, state_d;
   logic [TURN_CW-1:0] cnt_q, cnt_d;
   logic               tx_ready_c;
   logic               rx_flag;
   logic [WIDTH:0]     rx_pipe;

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state_q <= RECV;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_ready_c = 1'b0;
      case (state_q)
         RECV: begin
            if (DIR_REQ) begin
               state_d = TURN_TX;
               cnt_d   = TURN_LOAD;
            end
         end
         TURN_TX: begin
            // Dropping the request here is safe: the pad has not been driven yet.
            if (!DIR_REQ)            state_d = RECV;
            else if (cnt_q == '0)    state_d = DRIVE;
            if (cnt_q != '0)         cnt_d   = cnt_q - TURN_CW'(1);
         end
         DRIVE: begin
            tx_ready_c = DIR_REQ;
            if (!DIR_REQ) begin
               state_d = TURN_RX;
               cnt_d   = TURN_LOAD;
            end
         end
         TURN_RX: begin
            if (cnt_q == '0) state_d = RECV;
            else             cnt_d   = cnt_q - TURN_CW'(1);
         end
         default: state_d = RECV;
      endcase
   end

   assign TX_READY = tx_ready_c;

   // T is registered from the next state so it is low exactly while state_q is DRIVE.
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         T <= 1'b1;
         I <= '0;
      end else begin
         T <= (state_d != DRIVE);
         if (tx_ready_c && TX_VALID) I <= TX_DATA;
      end
   end

   assign rx_flag = (state_q == RECV);

   iobuf_dir_sync #(
      .STAGES (SYNC_N),
      .W      (WIDTH + 1)
   ) u_rx_sync (
      .C   (C),
      .CLR (CLR),
      .d   ({rx_flag, O}),
      .q   (rx_pipe)
   );

   assign RX_VALID = rx_pipe[WIDTH];
   assign RX_DATA  = rx_pipe[WIDTH-1:0];

`ifdef IOBUF_DIR_READBACK_CHECK_EN
   logic [WIDTH:0] shadow;
   logic           err_q;

   // Shadow of what was driven, delayed to line up with the synchronized readback.
   iobuf_dir_sync #(
      .STAGES (SYNC_N),
      .W      (WIDTH + 1)
   ) u_shadow (
      .C   (C),
      .CLR (CLR),
      .d   ({(T == 1'b0), I}),
      .q   (shadow)
   );

   always_ff @(posedge C or posedge CLR) begin
      if (CLR)                                                  err_q <= 1'b0;
      else if (shadow[WIDTH] && (RX_DATA != shadow[WIDTH-1:0])) err_q <= 1'b1;
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule
